// File: rtl/hp_arbiter_pkg.sv
// Shared FSM state type, AXI3 response codes and the fixed AXI attributes
// used by the two-port hp_arbiter.
package hp_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ISSUE  = 2'd1,
      ST_WAIT   = 2'd2,
      ST_RETURN = 2'd3
   } hp_state_e;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam int unsigned ID_W = 6;

   localparam logic [3:0] AXI_LEN   = 4'h0;
   localparam logic [2:0] AXI_SIZE  = 3'b010;
   localparam logic [1:0] AXI_BURST = 2'b00;
   localparam logic [1:0] AXI_LOCK  = 2'b00;
   localparam logic [3:0] AXI_CACHE = 4'b0011;
   localparam logic [2:0] AXI_PROT  = 3'b000;
   localparam logic [3:0] AXI_QOS   = 4'h0;
   localparam logic [3:0] AXI_WSTRB = 4'hF;

   // Transaction ID carries the requester index in its LSB.
   function automatic logic [ID_W-1:0] axi_id(input logic idx);
      return {{(ID_W-1){1'b0}}, idx};
   endfunction

endpackage

// File: rtl/hp_arbiter_if.sv
// AXI3 single-beat master bus between hp_arbiter (master) and its slave.
interface hp_arbiter_if;
   import hp_pkg::*;

   // Every channel: a transfer happens on a rising edge where valid and ready
   // are both high; valid never depends on ready, and payload is held stable
   // while valid is high and ready is low.
   logic            arvalid;
   logic            arready;
   logic [31:0]     araddr;
   logic [ID_W-1:0] arid;
   logic [3:0]      arlen;
   logic [2:0]      arsize;
   logic [1:0]      arburst;
   logic [1:0]      arlock;
   logic [3:0]      arcache;
   logic [2:0]      arprot;
   logic [3:0]      arqos;

   logic            awvalid;
   logic            awready;
   logic [31:0]     awaddr;
   logic [ID_W-1:0] awid;
   logic [3:0]      awlen;
   logic [2:0]      awsize;
   logic [1:0]      awburst;
   logic [1:0]      awlock;
   logic [3:0]      awcache;
   logic [2:0]      awprot;
   logic [3:0]      awqos;

   logic            wvalid;
   logic            wready;
   logic [31:0]     wdata;
   logic [ID_W-1:0] wid;
   logic            wlast;
   logic [3:0]      wstrb;

   logic            rvalid;
   logic            rready;
   logic [31:0]     rdata;
   logic [1:0]      rresp;
   logic [ID_W-1:0] rid;
   logic            rlast;

   logic            bvalid;
   logic            bready;
   logic [1:0]      bresp;
   logic [ID_W-1:0] bid;

   modport master (
      output arvalid, araddr, arid, arlen, arsize, arburst, arlock, arcache, arprot, arqos,
      input  arready,
      output awvalid, awaddr, awid, awlen, awsize, awburst, awlock, awcache, awprot, awqos,
      input  awready,
      output wvalid, wdata, wid, wlast, wstrb,
      input  wready,
      input  rvalid, rdata, rresp, rid, rlast,
      output rready,
      input  bvalid, bresp, bid,
      output bready
   );

   modport slave (
      input  arvalid, araddr, arid, arlen, arsize, arburst, arlock, arcache, arprot, arqos,
      output arready,
      input  awvalid, awaddr, awid, awlen, awsize, awburst, awlock, awcache, awprot, awqos,
      output awready,
      input  wvalid, wdata, wid, wlast, wstrb,
      output wready,
      output rvalid, rdata, rresp, rid, rlast,
      input  rready,
      output bvalid, bresp, bid,
      input  bready
   );

endinterface

// File: rtl/hp_arbiter_rr_arbiter.sv
// Two-way round-robin grant; the last-grant register starts at 1 so that
// requester 0 wins the first contested grant after reset.
module hp_rr_arbiter (
   input  logic       clock,
   input  logic       reset_n,
   input  logic [1:0] req_i,
   input  logic       accept_i,
   output logic [1:0] grant_o
);

   logic last_q;
   logic last_d;

   always_comb begin
      grant_o = req_i;
      if (req_i == 2'b11) begin
         grant_o = last_q ? 2'b01 : 2'b10;
      end
   end

   always_comb begin
      last_d = last_q;
      if (accept_i && (grant_o != 2'b00)) begin
         last_d = grant_o[1];
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/hp_arbiter.sv
// Two-requester arbiter onto an AXI3 master, one transaction in flight.
// Optional response watchdog enabled by defining HP_ARB_TIMEOUT_EN.
module hp_arbiter
   import hp_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [1:0]       req_valid,
   input  logic [1:0]       req_write,
   input  logic [1:0][31:0] req_addr,
   input  logic [1:0][31:0] req_data,
   output logic [1:0]       req_ready,
   output logic [1:0]       rsp_valid,
   input  logic [1:0]       rsp_ready,
   output logic [31:0]      rsp_data,
   output logic [1:0]       rsp_resp,
   hp_arbiter_if.master     axi,
   output logic             timeout_flag,
   output hp_state_e        dbg_state
);

   hp_state_e   state_q, state_d;
   logic        idx_q, idx_d;
   logic        write_q, write_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] data_q, data_d;
   logic        aw_done_q, aw_done_d;
   logic        w_done_q, w_done_d;
   logic [31:0] rsp_data_q, rsp_data_d;
   logic [1:0]  rsp_resp_q, rsp_resp_d;

   logic [1:0]      grant;
   logic            accept;
   logic [ID_W-1:0] cur_id;
   logic            ar_hs, aw_hs, w_hs, r_hit, b_hit;

   hp_rr_arbiter u_rr (
      .clock    (clock),
      .reset_n  (reset_n),
      .req_i    (req_valid),
      .accept_i (accept),
      .grant_o  (grant)
   );

   // Gated by reset_n so req_ready is quiet while reset is held.
   assign accept    = (state_q == ST_IDLE) && reset_n && (req_valid != 2'b00);
   assign req_ready = accept ? grant : 2'b00;
   assign cur_id    = axi_id(idx_q);

   assign axi.arvalid = (state_q == ST_ISSUE) && !write_q;
   assign axi.awvalid = (state_q == ST_ISSUE) && write_q && !aw_done_q;
   assign axi.wvalid  = (state_q == ST_ISSUE) && write_q && !w_done_q;
   assign axi.wlast   = axi.wvalid;
   assign axi.rready  = (state_q == ST_WAIT) && !write_q;
   assign axi.bready  = (state_q == ST_WAIT) && write_q;

   assign axi.araddr  = addr_q;
   assign axi.awaddr  = addr_q;
   assign axi.wdata   = data_q;
   assign axi.arid    = cur_id;
   assign axi.awid    = cur_id;
   assign axi.wid     = cur_id;
   assign axi.wstrb   = AXI_WSTRB;

   assign axi.arlen   = AXI_LEN;
   assign axi.arsize  = AXI_SIZE;
   assign axi.arburst = AXI_BURST;
   assign axi.arlock  = AXI_LOCK;
   assign axi.arcache = AXI_CACHE;
   assign axi.arprot  = AXI_PROT;
   assign axi.arqos   = AXI_QOS;
   assign axi.awlen   = AXI_LEN;
   assign axi.awsize  = AXI_SIZE;
   assign axi.awburst = AXI_BURST;
   assign axi.awlock  = AXI_LOCK;
   assign axi.awcache = AXI_CACHE;
   assign axi.awprot  = AXI_PROT;
   assign axi.awqos   = AXI_QOS;

   assign ar_hs = axi.arvalid && axi.arready;
   assign aw_hs = axi.awvalid && axi.awready;
   assign w_hs  = axi.wvalid && axi.wready;
   // Single-beat bursts: only a last beat carrying our ID completes the read.
   assign r_hit = axi.rready && axi.rvalid && (axi.rid == cur_id) && axi.rlast;
   assign b_hit = axi.bready && axi.bvalid && (axi.bid == cur_id);

   assign rsp_valid = (state_q == ST_RETURN) ? {idx_q, ~idx_q} : 2'b00;
   assign rsp_data  = rsp_data_q;
   assign rsp_resp  = rsp_resp_q;
   assign dbg_state = state_q;

`ifdef HP_ARB_TIMEOUT_EN
   localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [WD_W-1:0] wd_q, wd_d;
   logic            tmo_q, tmo_d;
   logic            wd_hit;

   assign wd_hit       = ((state_q == ST_ISSUE) || (state_q == ST_WAIT)) &&
                         (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
   assign timeout_flag = tmo_q;

   always_comb begin
      wd_d  = wd_q;
      tmo_d = tmo_q || wd_hit;
      if (accept) begin
         wd_d = '0;
      end else if ((state_q == ST_ISSUE) || (state_q == ST_WAIT)) begin
         wd_d = wd_q + 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wd_q  <= '0;
         tmo_q <= 1'b0;
      end else begin
         wd_q  <= wd_d;
         tmo_q <= tmo_d;
      end
   end
`else
   assign timeout_flag = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      write_d    = write_q;
      addr_d     = addr_q;
      data_d     = data_q;
      aw_done_d  = aw_done_q;
      w_done_d   = w_done_q;
      rsp_data_d = rsp_data_q;
      rsp_resp_d = rsp_resp_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               idx_d     = grant[1];
               write_d   = req_write[grant[1]];
               addr_d    = req_addr[grant[1]];
               data_d    = req_data[grant[1]];
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               state_d   = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (write_q) begin
               if (aw_hs) aw_done_d = 1'b1;
               if (w_hs)  w_done_d  = 1'b1;
               if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                  state_d = ST_WAIT;
               end
            end else if (ar_hs) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (r_hit) begin
               rsp_data_d = axi.rdata;
               rsp_resp_d = axi.rresp;
               state_d    = ST_RETURN;
            end else if (b_hit) begin
               rsp_data_d = 32'h0;
               rsp_resp_d = axi.bresp;
               state_d    = ST_RETURN;
            end
         end
         ST_RETURN: begin
            if (rsp_ready[idx_q]) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
`ifdef HP_ARB_TIMEOUT_EN
      // Watchdog wins over a transfer still stuck in ISSUE/WAIT.
      if (wd_hit && ((state_d == ST_ISSUE) || (state_d == ST_WAIT))) begin
         rsp_data_d = 32'h0;
         rsp_resp_d = RESP_SLVERR;
         state_d    = ST_RETURN;
      end
`endif
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         idx_q      <= 1'b0;
         write_q    <= 1'b0;
         addr_q     <= 32'h0;
         data_q     <= 32'h0;
         aw_done_q  <= 1'b0;
         w_done_q   <= 1'b0;
         rsp_data_q <= 32'h0;
         rsp_resp_q <= RESP_OKAY;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         write_q    <= write_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         aw_done_q  <= aw_done_d;
         w_done_q   <= w_done_d;
         rsp_data_q <= rsp_data_d;
         rsp_resp_q <= rsp_resp_d;
      end
   end

endmodule
